// File: rtl/sw_debounce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sw_debounce_pkg                                             |
// | Brief  : Shared constants for board and simulation debounce builds.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package sw_debounce_pkg;

  localparam int c_width             = 8;
  localparam int c_board_tick_div     = 1000;
  localparam int c_board_stable_ticks = 8;
  localparam int c_sim_tick_div       = 4;
  localparam int c_sim_stable_ticks   = 3;

  // Counter only ever reaches stable_ticks-1, but the +1 keeps stable_ticks=1 at one bit.
  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sw_debounce_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sw_debounce_if                                              |
// | Brief  : Raw switch inputs and debounced outputs with event pulses.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface sw_debounce_if
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH = c_width
);
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_stable;
  logic             any_on;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_change;

  modport master (
    output sw_in,
    input  sw_stable, any_on, sw_rise, sw_fall, sw_change
  );

  modport slave (
    input  sw_in,
    output sw_stable, any_on, sw_rise, sw_fall, sw_change
  );
endinterface
`default_nettype wire

// File: rtl/sw_debounce_bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sw_debounce_bit                                             |
// | Brief  : One switch bit: 2-flop sync, tick counter, stable flop.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = c_sim_stable_ticks
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic tick,
  input  wire logic sw_in,
  output logic      stable,
  output logic      stable_nxt,
  output logic      rise,
  output logic      fall
);
  localparam int CNT_W = cnt_width(STABLE_TICKS);

  logic             r_meta;
  logic             r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             r_rise;
  logic             r_fall;
  logic             w_diff;
  logic             w_accept;

  assign w_diff     = (r_sync != r_stable);
  assign w_accept   = w_diff && tick && (r_cnt == CNT_W'(STABLE_TICKS - 1));
  assign stable_nxt = w_accept ? r_sync : r_stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_meta   <= sw_in;
      r_sync   <= r_meta;
      r_stable <= stable_nxt;
      r_rise   <= w_accept &  r_sync;
      r_fall   <= w_accept & ~r_sync;
      // Any return to the stable level wipes progress, even between ticks.
      if (!w_diff || w_accept) begin
        r_cnt <= '0;
      end else if (tick) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable = r_stable;
  assign rise   = r_rise;
  assign fall   = r_fall;
endmodule
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sw_debounce                                                 |
// | Brief  : WIDTH-bit switch debouncer feeding the priority encoder.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH        = c_width,
  parameter int TICK_DIV     = c_board_tick_div,
  parameter int STABLE_TICKS = c_board_stable_ticks
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  sw_debounce_if.slave  bus
);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  logic             r_any_on;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_stable_nxt;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  // With TICK_DIV=1 the divider sits at 0, which is also the terminal count.
  assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div    <= '0;
      r_any_on <= 1'b0;
    end else begin
      r_div    <= w_tick ? '0 : r_div + 1'b1;
      r_any_on <= |w_stable_nxt;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_bit (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (w_tick),
      .sw_in      (bus.sw_in[i]),
      .stable     (w_stable[i]),
      .stable_nxt (w_stable_nxt[i]),
      .rise       (w_rise[i]),
      .fall       (w_fall[i])
    );
  end

  assign bus.sw_stable = w_stable;
  assign bus.sw_rise   = w_rise;
  assign bus.sw_fall   = w_fall;
  assign bus.any_on    = r_any_on;
  assign bus.sw_change = |(w_rise | w_fall);
endmodule
`default_nettype wire
